// File: rtl/bitbrick_serial_mult.sv
// Digit-serial WIDTH x WIDTH multiplier built from 2-bit bitbrick steps, with
// per-operand signedness, an optional running accumulator and valid/ready on both sides.
//
// state | meaning
// IDLE  | waiting for an operand request (in_ready=1)
// CALC  | one bitbrick partial product per cycle, N*N cycles
// DONE  | product held on p/acc until out_ready (out_valid=1)
module bitbrick_serial_mult #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 2*WIDTH+8
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       a,
    input  logic [WIDTH-1:0]       b,
    input  logic                   a_signed,
    input  logic                   b_signed,
    input  logic                   acc_en,
    input  logic                   acc_clr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*WIDTH-1:0]     p,
    output logic [ACC_WIDTH-1:0]   acc
);

    localparam int N  = WIDTH/2;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = 2*WIDTH;
    localparam logic [CW-1:0] LAST = CW'(N-1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic                 as_q;
    logic                 bs_q;
    logic                 ae_q;
    logic                 ac_q;
    logic [CW-1:0]        i_q;
    logic [CW-1:0]        j_q;
    logic [PW-1:0]        psum;

    logic [1:0]           da;
    logic [1:0]           db;
    logic signed [2:0]    sa;
    logic signed [2:0]    sb;
    logic signed [5:0]    prod;
    logic [PW+5:0]        prod_ext;
    logic [PW+5:0]        shifted;
    logic [CW:0]          dsum;
    logic [PW-1:0]        sum_next;
    logic [ACC_WIDTH-1:0] p_ext;
    logic                 last_step;

    always_comb begin
        da        = 2'(a_q >> {i_q, 1'b0});
        db        = 2'(b_q >> {j_q, 1'b0});
        // only the top digit of a signed operand carries the sign weight
        sa        = {as_q && (i_q == LAST) && da[1], da};
        sb        = {bs_q && (j_q == LAST) && db[1], db};
        prod      = sa * sb;
        prod_ext  = {{PW{prod[5]}}, prod};
        dsum      = {1'b0, i_q} + {1'b0, j_q};
        shifted   = prod_ext << {dsum, 1'b0};
        sum_next  = psum + shifted[PW-1:0];
        last_step = (i_q == LAST) && (j_q == LAST);
        p_ext     = {ACC_WIDTH{(as_q | bs_q) & sum_next[PW-1]}};
        p_ext[PW-1:0] = sum_next;
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            p         <= '0;
            acc       <= '0;
            i_q       <= '0;
            j_q       <= '0;
            psum      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            as_q      <= 1'b0;
            bs_q      <= 1'b0;
            ae_q      <= 1'b0;
            ac_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        as_q     <= a_signed;
                        bs_q     <= b_signed;
                        ae_q     <= acc_en;
                        ac_q     <= acc_clr;
                        psum     <= '0;
                        i_q      <= '0;
                        j_q      <= '0;
                        state    <= CALC;
                        in_ready <= 1'b0;
                    end
                end
                CALC: begin
                    psum <= sum_next;
                    if (last_step) begin
                        p <= sum_next;
                        if (ae_q) begin
                            acc <= ac_q ? p_ext : acc + p_ext;
                        end
                        i_q       <= '0;
                        j_q       <= '0;
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else if (j_q == LAST) begin
                        j_q <= '0;
                        i_q <= i_q + 1'b1;
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/bitbrick_serial_mult.md
Name: bitbrick_serial_mult

Overview:
Parametrised, digit-serial successor to the 2-bit bitbrick. It multiplies two WIDTH-bit operands by decomposing each into 2-bit digits. One bitbrick partial product is evaluated per cycle and shift-accumulated into the full product. Per-operand signedness is selectable. An optional running accumulator provides MAC use. It sits between the operand fetch stage and the output buffer in the sparse DNN datapath, with valid/ready handshakes on both sides.

Parameters:
WIDTH, 8, operand width in bits; must be even and >= 2; N = WIDTH/2 digits per operand
ACC_WIDTH, 2*WIDTH+8, accumulator width; must be >= 2*WIDTH

Ports:
clk  input  1  clock, all logic on rising edge
nrst  input  1  synchronous active-low reset
in_valid  input  1  operand request valid
in_ready  output  1  block can accept an operand request
a  input  WIDTH  operand A
b  input  WIDTH  operand B
a_signed  input  1  1 = A is two's complement
b_signed  input  1  1 = B is two's complement
acc_en  input  1  add this product into acc on completion
acc_clr  input  1  with acc_en: acc is loaded with the product instead of adding to it
out_valid  output  1  product valid
out_ready  input  1  downstream accepts product
p  output  2*WIDTH  product, two's complement if a_signed or b_signed, else unsigned
acc  output  ACC_WIDTH  running accumulator, two's complement

Behaviour:
- Reset (nrst low at a clock edge):
  - State goes to IDLE.
  - out_valid=0, p=0, acc=0, digit counters=0, partial sum=0.
  - in_ready reads 1 on the first cycle after reset.
  - Reset overrides all activity, including mid-CALC; an in-flight operation is discarded.
- FSM states: IDLE, CALC, DONE.
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
- IDLE:
  - If in_valid, latch a, b, a_signed, b_signed, acc_en and acc_clr.
  - Clear the partial sum, set i=0, j=0, and go to CALC.
- CALC runs one bitbrick step per cycle:
  - Operand digits: da = a[2i+1:2i], db = b[2j+1:2j].
  - Digit da is signed only if i==N-1 and a_signed; db is signed only if j==N-1 and b_signed.
  - Each digit is extended to 3 bits (sign bit = digit MSB if signed, else 0).
  - Their 5-bit signed product is sign-extended to 2*WIDTH, shifted left by 2*(i+j), and added to the partial sum modulo 2^(2*WIDTH).
  - Counter order: j increments first; when j wraps from N-1 to 0, i increments.
  - After the step with i=N-1, j=N-1:
    - p <= final sum; go to DONE.
    - If acc_en: acc <= (acc_clr ? ext(p) : acc + ext(p)), where ext = sign-extension if a_signed|b_signed, else zero-extension.
    - Accumulator wraps modulo 2^ACC_WIDTH with no saturation.
- Latency:
  - CALC lasts exactly N*N cycles (16 for WIDTH=8).
  - out_valid rises N*N+1 clock edges after the accepting edge.
- DONE:
  - p and acc are held stable while out_valid=1 and out_ready=0.
  - When out_ready=1, go to IDLE.
  - in_ready stays low during DONE; new input is accepted no earlier than the cycle after the handshake, giving a throughput of 1 result per N*N+2 cycles.
- in_valid while not in IDLE is ignored; operands are not sampled.
- p is unchanged from the previous result until the next completion.
- acc is readable at all times and changes only on the completion edge or on reset.
- WIDTH=2 degenerates to a single-step bitbrick, with 1 CALC cycle.

Test Plan:
- Unsigned max, WIDTH=8: a=0xFF, b=0xFF, both signs 0, out_ready=1 → out_valid exactly 17 edges after accept, p=0xFE01, in_ready=1 on the following cycle.
- Signed×signed: a=0x80 (-128), b=0x80 (-128), a_signed=b_signed=1 → p=0x4000. Also a=0x80, b=0x7F (127) → p=0xC080 (-16256).
- Mixed sign: a=0xFF signed (-1), b=0xFF unsigned (255) → p=0xFF01 (-255). Swap the sign flags → same p.
- Backpressure: complete with out_ready=0 for 5 cycles → out_valid=1, p stable, in_ready=0, and pulses on in_valid are ignored. Raising out_ready → next-cycle IDLE, then a new accept.
- Accumulate: 3×4 with acc_en=1, acc_clr=1 → acc=12. Then 5×6 with acc_en=1, acc_clr=0 → acc=42. Then signed -2×7 (0xFE, 0x07) with acc_en=1 → acc=28. Then 9×9 with acc_en=0 → acc stays 28, p=81.
- Reset mid-operation: nrst low for 1 cycle during the 8th CALC cycle → next cycle out_valid=0, p=0, acc=0, in_ready=1. A following 2×3 → p=6 with full 17-edge latency.
